// File: rtl/spi_ramp_sched.sv
// -----------------------------------------------------------------------------
// spi_ramp_sched
//
// Purpose:
//   Slews a signed 16-bit motor speed word toward a requested target in steps
//   of at most STEP_SIZE.
//   Each intermediate speed is handed to an external SPI shifter with a
//   start/ready handshake.
//   After each transmit, an idle gap of GAP_CYCLES clocks is inserted before
//   the next step is taken.
//
// Ports:
//   PCLK            in   sole clock, rising edge
//   PRESETn         in   asynchronous active-low reset
//   i_enable        in   ramping permitted when high
//   i_target_valid  in   one-cycle strobe qualifying i_target (always latched)
//   i_target[15:0]  in   requested speed, signed two's complement
//   i_spi_ready     in   one-cycle transmit-done pulse (PCLK domain)
//   o_spi_start     out  level request to shifter, held until i_spi_ready
//   o_motor_speed   out  signed speed word presented to the shifter
//   o_busy          out  high in any state other than IDLE
//   o_at_target     out  speed register equals target register
//   o_timeout       out  sticky handshake-timeout flag
//
// Build option:
//   SPI_RAMP_TIMEOUT_EN - when defined, WAIT is bounded by TIMEOUT_CYCLES clocks
//   of o_spi_start. On expiry the request drops, o_timeout sets, and the block
//   returns to IDLE. When undefined, WAIT is unbounded and o_timeout is tied
//   low.
//
// States:
//   state | meaning
//   IDLE  | holding speed, waiting for a target strobe with enable
//   STEP  | move speed one step toward target
//   START | first cycle of the shifter request
//   WAIT  | request held, waiting for i_spi_ready
//   GAP   | post-transmit idle gap, then decide STEP or IDLE
// -----------------------------------------------------------------------------
module spi_ramp_sched #(
    parameter logic [15:0] STEP_SIZE      = 16'd64,
    parameter logic [11:0] GAP_CYCLES     = 12'd2001,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        i_enable,
    input  logic        i_target_valid,
    input  logic [15:0] i_target,
    input  logic        i_spi_ready,
    output logic        o_spi_start,
    output logic [15:0] o_motor_speed,
    output logic        o_busy,
    output logic        o_at_target,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] speed_q, speed_d;
    logic [15:0] target_q, target_d;
    logic [11:0] gap_cnt_q, gap_cnt_d;
    logic        spi_start_q, spi_start_d;

`ifdef SPI_RAMP_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Step arithmetic.
    // The difference is formed in 17 bits so that the full signed range of
    // the target and speed words cannot overflow.
    logic [16:0] diff;
    logic [16:0] diff_mag;
    logic [15:0] speed_stepped;

    always_comb begin
        diff     = {target_q[15], target_q} - {speed_q[15], speed_q};
        diff_mag = diff[16] ? (17'd0 - diff) : diff;
        if (diff_mag <= {1'b0, STEP_SIZE}) begin
            speed_stepped = target_q;
        end else if (diff[16]) begin
            speed_stepped = speed_q - STEP_SIZE;
        end else begin
            speed_stepped = speed_q + STEP_SIZE;
        end
    end

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        target_d  = i_target_valid ? i_target : target_q;
        gap_cnt_d = gap_cnt_q;
`ifdef SPI_RAMP_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = i_target_valid ? 1'b0 : timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_target_valid && i_enable) begin
                    state_d = S_STEP;
                end
            end

            S_STEP: begin
                speed_d = speed_stepped;
                state_d = S_START;
`ifdef SPI_RAMP_TIMEOUT_EN
                // Budget starts with the START cycle, the first cycle the
                // request is visible to the shifter.
                to_cnt_d = TIMEOUT_CYCLES - 16'd1;
`endif
            end

            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_RAMP_TIMEOUT_EN
                if (to_cnt_q != 16'd0) begin
                    to_cnt_d = to_cnt_q - 16'd1;
                end
`endif
            end

            S_WAIT: begin
                if (i_spi_ready) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_CYCLES - 12'd1;
                end
`ifdef SPI_RAMP_TIMEOUT_EN
                else if (to_cnt_q == 16'd0) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - 16'd1;
                end
`endif
            end

            S_GAP: begin
                if (gap_cnt_q == 12'd0) begin
                    // Compare against target_d so that a target strobe
                    // arriving in this very cycle is not lost.
                    if ((speed_q != target_d) && i_enable) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 12'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so the request is a clean flop output to the shifter.
        spi_start_d = (state_d == S_START) || (state_d == S_WAIT);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            speed_q     <= 16'd0;
            target_q    <= 16'd0;
            gap_cnt_q   <= 12'd0;
            spi_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            target_q    <= target_d;
            gap_cnt_q   <= gap_cnt_d;
            spi_start_q <= spi_start_d;
        end
    end

`ifdef SPI_RAMP_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_spi_start   = spi_start_q;
    assign o_motor_speed = speed_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_at_target   = (speed_q == target_q);

endmodule

// File: tb/tb_spi_ramp_sched.sv
module tb_spi_ramp_sched;

    localparam int STEP = 64;
    localparam int GAP  = 25;
    localparam int TOUT = 60;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        i_enable;
    logic        i_target_valid;
    logic [15:0] i_target;
    logic        i_spi_ready;
    logic        o_spi_start;
    logic [15:0] o_motor_speed;
    logic        o_busy;
    logic        o_at_target;
    logic        o_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int model_speed = 0;

    spi_ramp_sched #(
        .STEP_SIZE(16'(STEP)),
        .GAP_CYCLES(12'(GAP)),
        .TIMEOUT_CYCLES(16'(TOUT))
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .i_enable(i_enable),
        .i_target_valid(i_target_valid),
        .i_target(i_target),
        .i_spi_ready(i_spi_ready),
        .o_spi_start(o_spi_start),
        .o_motor_speed(o_motor_speed),
        .o_busy(o_busy),
        .o_at_target(o_at_target),
        .o_timeout(o_timeout)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference stepping rule: move toward target by at most STEP.
    function automatic int next_speed(input int s, input int t);
        int d;
        d = t - s;
        if (d <= STEP && d >= -STEP) return t;
        return (d > 0) ? s + STEP : s - STEP;
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        model_speed = 0;
    endtask

    task automatic strobe(input int tgt, input logic en);
        logic [31:0] tv;
        tv = tgt;
        i_target       = tv[15:0];
        i_enable       = en;
        i_target_valid = 1'b1;
        tick();
        i_target_valid = 1'b0;
    endtask

    // One complete transmit: waits for the request, holds i_spi_ready off for
    // d WAIT cycles, then measures the idle time that follows.
    task automatic xmit(input int exp_speed, input int d, input bit last,
                        input bit chg, input int chg_val, input bit drop_en);
        int guard, hi, gapc;
        bit stable;
        logic [31:0] cv;
        guard = 0;
        while (!o_spi_start && guard < 200) begin
            tick();
            guard++;
        end
        chk("start_seen", 32'(o_spi_start), 1);
        chk("xmit_speed", $signed(o_motor_speed), exp_speed);
        hi = 1;
        stable = 1'b1;
        for (int i = 0; i < d; i++) begin
            tick();
            i_target_valid = 1'b0;
            if (o_spi_start) hi++;
            if ($signed(o_motor_speed) != exp_speed) stable = 1'b0;
            if (i == 0 && chg) begin
                cv = chg_val;
                i_target = cv[15:0];
                i_target_valid = 1'b1;
            end
        end
        i_spi_ready = 1'b1;
        if (drop_en) i_enable = 1'b0;
        tick();
        i_spi_ready = 1'b0;
        i_target_valid = 1'b0;
        chk("start_high_cycles", hi, d + 1);
        chk("start_fell", 32'(o_spi_start), 0);
        chk("speed_stable", 32'(stable), 1);
        gapc = 0;
        while (o_busy && !o_spi_start && gapc < GAP + 10) begin
            tick();
            gapc++;
        end
        if (last) begin
            chk("gap_to_idle", gapc, GAP);
            chk("busy_low", 32'(o_busy), 0);
        end else begin
            chk("gap_to_next", gapc, GAP + 1);
        end
    endtask

    task automatic run_ramp(input int tgt);
        int q[$];
        int s;
        s = model_speed;
        do begin
            s = next_speed(s, tgt);
            q.push_back(s);
        end while (s != tgt);
        strobe(tgt, 1'b1);
        foreach (q[i]) xmit(q[i], $urandom_range(1, 4), i == q.size() - 1, 1'b0, 0, 1'b0);
        model_speed = tgt;
        chk("ramp_at_target", 32'(o_at_target), 1);
        chk("ramp_final_speed", $signed(o_motor_speed), tgt);
    endtask

    initial begin
        int guard, hi;
        PRESETn        = 1'b0;
        i_enable       = 1'b0;
        i_target_valid = 1'b0;
        i_target       = 16'd0;
        i_spi_ready    = 1'b0;
        #22;
        chk("rst_speed", 32'(o_motor_speed), 0);
        chk("rst_start", 32'(o_spi_start), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_at_target", 32'(o_at_target), 1);
        chk("rst_timeout", 32'(o_timeout), 0);
        PRESETn = 1'b1;
        tick();

        // 0 -> 200: 64,128,192,200
        strobe(200, 1'b1);
        xmit(64, 1, 0, 0, 0, 0);
        xmit(128, 2, 0, 0, 0, 0);
        xmit(192, 1, 0, 0, 0, 0);
        xmit(200, 3, 1, 0, 0, 0);
        chk("r200_at_target", 32'(o_at_target), 1);

        // 0 -> -100: -64,-100
        do_reset();
        strobe(-100, 1'b1);
        xmit(-64, 1, 0, 0, 0, 0);
        xmit(-100, 2, 1, 0, 0, 0);
        chk("neg_at_target", 32'(o_at_target), 1);

        // target 1000, retarget to 64 during second WAIT
        do_reset();
        strobe(1000, 1'b1);
        xmit(64, 2, 0, 0, 0, 0);
        xmit(128, 3, 0, 1, 64, 0);
        xmit(64, 1, 1, 0, 0, 0);
        chk("retgt_at_target", 32'(o_at_target), 1);

        // ready held off: start high 10 cycles, exact gap
        do_reset();
        strobe(50, 1'b1);
        xmit(50, 9, 1, 0, 0, 0);

        // enable dropped mid-ramp: finish transmit and gap, hold speed
        strobe(1000, 1'b1);
        xmit(114, 2, 1, 0, 0, 1);
        repeat (5) tick();
        chk("hold_speed", $signed(o_motor_speed), 114);
        chk("hold_busy", 32'(o_busy), 0);
        chk("hold_at_target", 32'(o_at_target), 0);

        // strobe with enable low latches only
        strobe(114, 1'b0);
        tick();
        chk("latch_only_busy", 32'(o_busy), 0);
        chk("latch_only_at_target", 32'(o_at_target), 1);

        // equal target still refreshes once
        strobe(114, 1'b1);
        xmit(114, 1, 1, 0, 0, 0);

        // randomized ramps
        model_speed = 114;
        for (int k = 0; k < 6; k++) begin
            run_ramp(int'($urandom_range(0, 800)) - 400);
            repeat ($urandom_range(0, 3)) tick();
        end

        // stray ready in IDLE
        i_spi_ready = 1'b1;
        tick();
        i_spi_ready = 1'b0;
        tick();
        chk("idle_ready_start", 32'(o_spi_start), 0);
        chk("idle_ready_busy", 32'(o_busy), 0);

        // reset during WAIT at speed 128
        do_reset();
        strobe(1000, 1'b1);
        xmit(64, 1, 0, 0, 0, 0);
        guard = 0;
        while (!o_spi_start && guard < 50) begin
            tick();
            guard++;
        end
        chk("w128_speed", $signed(o_motor_speed), 128);
        tick();
        chk("w128_in_wait", 32'(o_spi_start), 1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_start", 32'(o_spi_start), 0);
        chk("arst_speed", 32'(o_motor_speed), 0);
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_at_target", 32'(o_at_target), 1);
        tick();
        PRESETn = 1'b1;
        i_spi_ready = 1'b1;
        tick();
        i_spi_ready = 1'b0;
        repeat (3) tick();
        chk("post_rst_start", 32'(o_spi_start), 0);
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("post_rst_timeout", 32'(o_timeout), 0);

`ifdef SPI_RAMP_TIMEOUT_EN
        strobe(300, 1'b1);
        guard = 0;
        while (!o_spi_start && guard < 20) begin
            tick();
            guard++;
        end
        hi = 0;
        while (o_spi_start && hi < TOUT + 10) begin
            hi++;
            tick();
        end
        chk("to_start_cycles", hi, TOUT);
        chk("to_flag", 32'(o_timeout), 1);
        chk("to_busy", 32'(o_busy), 0);
        strobe(64, 1'b0);
        chk("to_cleared", 32'(o_timeout), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ramp_sched.md
SPI_RAMP_SCHED -- requirements
Module: spi_ramp_sched

Interface
REQ-001 SHALL have parameter STEP_SIZE, default 16'd64, max speed change per SPI transmit (unsigned, nonzero).
REQ-002 SHALL have parameter GAP_CYCLES, default 12'd2001, idle PCLK cycles between transmit completion and next step.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16'd4000, PCLK cycles allowed for i_spi_ready after o_spi_start rises.
REQ-004 PCLK  input  1  sole clock, rising edge.
REQ-005 PRESETn  input  1  asynchronous, active-low reset.
REQ-006 i_enable  input  1  ramping permitted when high.
REQ-007 i_target_valid  input  1  one-cycle strobe qualifying i_target.
REQ-008 i_target  input  16  requested motor speed, signed two's complement.
REQ-009 i_spi_ready  input  1  one-PCLK pulse, transmit done (already synchronized to PCLK).
REQ-010 o_spi_start  output  1  level request to shifter, held until i_spi_ready.
REQ-011 o_motor_speed  output  16  signed speed word presented to shifter.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_at_target  output  1  high when o_motor_speed equals latched target.
REQ-014 o_timeout  output  1  sticky error flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, STEP, START, WAIT, GAP.
REQ-016 Any cycle with i_target_valid high SHALL latch i_target into target register, regardless of state.
REQ-017 IDLE->STEP the cycle after a latching i_target_valid when i_enable high; i_target_valid with i_enable low SHALL latch only.
REQ-018 STEP SHALL compute diff = target - speed in 17 bits; |diff| <= STEP_SIZE -> speed = target; else speed += STEP_SIZE or -= STEP_SIZE by sign; STEP->START in one cycle.
REQ-019 Target equal to current speed SHALL still produce one refresh transmit.
REQ-020 START SHALL assert o_spi_start and go to WAIT next cycle; o_spi_start SHALL stay high through WAIT until the cycle after i_spi_ready, then fall.
REQ-021 o_motor_speed SHALL remain stable from START until WAIT exits.
REQ-022 i_spi_ready outside WAIT SHALL be ignored.
REQ-023 WAIT->GAP on i_spi_ready; GAP counter loads GAP_CYCLES-1 and counts to 0.
REQ-024 At GAP end: speed != target and i_enable high -> STEP; otherwise -> IDLE.
REQ-025 New target during START/WAIT/GAP SHALL not abort transmit; it SHALL take effect at next STEP.
REQ-026 i_enable low mid-ramp SHALL complete current transmit and GAP, then IDLE, holding o_motor_speed.
REQ-027 o_at_target SHALL be combinational compare of speed and target registers.

Reset
REQ-028 PRESETn low SHALL asynchronously force IDLE, o_motor_speed=0, target=0, o_spi_start=0, o_busy=0, o_timeout=0, counters=0; o_at_target thus 1.
REQ-029 Reset mid-WAIT SHALL drop o_spi_start immediately; a later i_spi_ready SHALL be ignored.

Configuration
REQ-030 Macro SPI_RAMP_TIMEOUT_EN defined: WAIT counter SHALL count TIMEOUT_CYCLES; expiry without i_spi_ready SHALL drop o_spi_start, set o_timeout, go IDLE; o_timeout clears only on reset or next accepted i_target_valid.
REQ-031 Macro undefined: no timeout counter; WAIT waits indefinitely; o_timeout SHALL be tied 0.

Verification
REQ-032 Reset, target 200, enable, STEP_SIZE 64 -> transmits with speeds 64,128,192,200, then IDLE, o_at_target=1.
REQ-033 Speed 0, target -100 -> transmits -64, -100; o_motor_speed sign-correct.
REQ-034 Target 1000 accepted, during 2nd WAIT write target 64 -> ramp 64,128 then 64; no transmit aborted.
REQ-035 i_spi_ready held off 10 cycles -> o_spi_start high 10 cycles, o_motor_speed stable; GAP exactly GAP_CYCLES cycles.
REQ-036 SPI_RAMP_TIMEOUT_EN, no i_spi_ready -> o_timeout=1 after TIMEOUT_CYCLES, IDLE; next target valid clears it.
REQ-037 PRESETn low during WAIT at speed 128 -> outputs to reset values same cycle; stray i_spi_ready ignored.
